// File: rtl/alu_seq_core.sv
// Registered SAP ALU: 8 ops, latched NZCV flags, Start/Busy/Done handshake, Result drives the bus via ALUOut.
// Define ALU_MUL_EN to build op 7 as a WIDTH-cycle shift-add multiplier; otherwise op 7 is a single-cycle pass-through of A.
module alu_seq_core #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Accumulator,
  input  logic [WIDTH-1:0] BRegister,
  input  logic [2:0]       Operation,
  input  logic             Start,
  input  logic             ALUOut,
  output logic [WIDTH-1:0] BusOut,
  output logic [WIDTH-1:0] ProductHigh,
  output logic [3:0]       Flags,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  logic             issue;
  logic             is_mul;
  logic             mul_last;
  logic [WIDTH:0]   add_full, sub_full;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [3:0]       alu_flags;

  assign issue = (state_q == S_IDLE) && Start;

  // Single-cycle ops; op 7 falls through as A so the non-multiplier build is complete
  always_comb begin
    add_full = {1'b0, Accumulator} + {1'b0, BRegister};
    sub_full = {1'b0, Accumulator} - {1'b0, BRegister};
    alu_res  = Accumulator;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (Operation)
      3'd0: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (Accumulator[WIDTH-1] == BRegister[WIDTH-1]) &&
                  (add_full[WIDTH-1] != Accumulator[WIDTH-1]);
      end
      3'd1: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (Accumulator[WIDTH-1] != BRegister[WIDTH-1]) &&
                  (sub_full[WIDTH-1] != Accumulator[WIDTH-1]);
      end
      3'd2: alu_res = Accumulator & BRegister;
      3'd3: alu_res = Accumulator | BRegister;
      3'd4: alu_res = Accumulator ^ BRegister;
      3'd5: begin
        alu_res = {Accumulator[WIDTH-2:0], 1'b0};
        alu_c   = Accumulator[WIDTH-1];
      end
      3'd6: begin
        alu_res = {1'b0, Accumulator[WIDTH-1:1]};
        alu_c   = Accumulator[0];
      end
      default: alu_res = Accumulator;
    endcase
    alu_flags = {alu_res[WIDTH-1], alu_v, alu_c, (alu_res == '0)};
  end

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] p_step;
  logic [WIDTH-1:0]   ph_q, ph_d;

  assign is_mul   = (Operation == 3'd7);
  assign mul_last = (state_q == S_MULT) && (cnt_q == CW'(WIDTH - 1));

  // p holds {partial product, remaining multiplier bits}; each step consumes p[0] and shifts right
  always_comb begin
    step_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? a_q : {WIDTH{1'b0}})};
    p_step   = {step_sum, p_q[WIDTH-1:1]};
  end

  always_comb begin
    a_d   = a_q;
    p_d   = p_q;
    cnt_d = cnt_q;
    ph_d  = ph_q;
    if (issue && is_mul) begin
      a_d   = Accumulator;
      p_d   = {{WIDTH{1'b0}}, BRegister};
      cnt_d = '0;
    end else if (state_q == S_MULT) begin
      p_d   = p_step;
      cnt_d = cnt_q + CW'(1);
      if (mul_last) ph_d = p_step[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      a_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
      ph_q  <= '0;
    end else begin
      a_q   <= a_d;
      p_q   <= p_d;
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
    end
  end

  assign ProductHigh = ph_q;
`else
  assign is_mul      = 1'b0;
  assign mul_last    = 1'b0;
  assign ProductHigh = '0;
`endif

  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
    if (issue && !is_mul) begin
      result_d = alu_res;
      flags_d  = alu_flags;
    end
`ifdef ALU_MUL_EN
    if (mul_last) begin
      result_d = p_step[WIDTH-1:0];
      flags_d  = {p_step[WIDTH-1],
                  (p_step[2*WIDTH-1:WIDTH] != '0),
                  (p_step[2*WIDTH-1:WIDTH] != '0),
                  (p_step == '0)};
    end
`endif
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = is_mul ? S_MULT : S_DONE;
      S_MULT:  if (mul_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Busy = (state_q != S_IDLE);
    Done = (state_q == S_DONE);
  end

  assign BusOut = ALUOut ? result_q : '0;
  assign Flags  = flags_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core at WIDTH=8; op 7 expectations follow whether ALU_MUL_EN is defined.
module tb_alu_seq_core;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] Accumulator, BRegister;
  logic [2:0] Operation;
  logic       Start, ALUOut;
  logic [7:0] BusOut, ProductHigh;
  logic [3:0] Flags;
  logic       Busy, Done;

  int cmp_count  = 0;
  int fail_count = 0;

  alu_seq_core #(.WIDTH(8)) dut (
    .Clock(Clock), .Reset(Reset), .Accumulator(Accumulator), .BRegister(BRegister),
    .Operation(Operation), .Start(Start), .ALUOut(ALUOut), .BusOut(BusOut),
    .ProductHigh(ProductHigh), .Flags(Flags), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  // Issues one op and returns how many edges after E0 Done was seen (0 for single-cycle ops)
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       output int edges);
    @(negedge Clock);
    Accumulator = a; BRegister = b; Operation = op; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    edges = 0;
    while (Done !== 1'b1 && edges < 40) begin
      @(negedge Clock);
      edges++;
    end
    @(negedge Clock);
  endtask

  task automatic test_reset;
    Reset = 1'b1; Start = 1'b0; ALUOut = 1'b1;
    Accumulator = 8'h00; BRegister = 8'h00; Operation = 3'd0;
    #12;
    cmp_count++; if (BusOut !== 8'h00) begin fail_count++; $display("FAIL reset_bus got %h want 00", BusOut); end
    cmp_count++; if (ProductHigh !== 8'h00) begin fail_count++; $display("FAIL reset_ph got %h want 00", ProductHigh); end
    cmp_count++; if ({Flags, Busy, Done} !== 6'b0) begin fail_count++; $display("FAIL reset_ctl got %b want 000000", {Flags, Busy, Done}); end
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_add;
    int edges;
    ALUOut = 1'b0;
    @(negedge Clock);
    Accumulator = 8'h06; BRegister = 8'h02; Operation = 3'd0; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    cmp_count++; if ({Busy, Done} !== 2'b11) begin fail_count++; $display("FAIL add_e0_busy_done got %b want 11", {Busy, Done}); end
    cmp_count++; if (BusOut !== 8'h00) begin fail_count++; $display("FAIL add_bus_gated got %h want 00", BusOut); end
    @(negedge Clock);
    cmp_count++; if ({Busy, Done} !== 2'b00) begin fail_count++; $display("FAIL add_idle got %b want 00", {Busy, Done}); end
    cmp_count++; if (Flags !== 4'b0000) begin fail_count++; $display("FAIL add_flags got %b want 0000", Flags); end
    ALUOut = 1'b1; #1;
    cmp_count++; if (BusOut !== 8'h08) begin fail_count++; $display("FAIL add_bus got %h want 08", BusOut); end
    do_op(8'h7F, 8'h01, 3'd0, edges);
    cmp_count++; if ({BusOut, Flags} !== {8'h80, 4'b1100}) begin fail_count++; $display("FAIL add_ovf got %h/%b want 80/1100", BusOut, Flags); end
    do_op(8'hFF, 8'h01, 3'd0, edges);
    cmp_count++; if ({BusOut, Flags} !== {8'h00, 4'b0011}) begin fail_count++; $display("FAIL add_carry got %h/%b want 00/0011", BusOut, Flags); end
    cmp_count++; if (edges !== 0) begin fail_count++; $display("FAIL add_latency got %0d want 0", edges); end
  endtask

  task automatic test_sub;
    int edges;
    do_op(8'h06, 8'h06, 3'd1, edges);
    cmp_count++; if ({BusOut, Flags} !== {8'h00, 4'b0001}) begin fail_count++; $display("FAIL sub_zero got %h/%b want 00/0001", BusOut, Flags); end
    do_op(8'h02, 8'h06, 3'd1, edges);
    cmp_count++; if ({BusOut, Flags} !== {8'hFC, 4'b1010}) begin fail_count++; $display("FAIL sub_borrow got %h/%b want FC/1010", BusOut, Flags); end
    do_op(8'h80, 8'h01, 3'd1, edges);
    cmp_count++; if ({BusOut, Flags} !== {8'h7F, 4'b0100}) begin fail_count++; $display("FAIL sub_ovf got %h/%b want 7F/0100", BusOut, Flags); end
  endtask

  task automatic test_logic_shift;
    int edges;
    do_op(8'h81, 8'h00, 3'd5, edges);
    cmp_count++; if ({BusOut, Flags} !== {8'h02, 4'b0010}) begin fail_count++; $display("FAIL shl got %h/%b want 02/0010", BusOut, Flags); end
    do_op(8'h01, 8'h00, 3'd6, edges);
    cmp_count++; if ({BusOut, Flags} !== {8'h00, 4'b0011}) begin fail_count++; $display("FAIL shr got %h/%b want 00/0011", BusOut, Flags); end
    do_op(8'hF0, 8'h0F, 3'd2, edges);
    cmp_count++; if ({BusOut, Flags} !== {8'h00, 4'b0001}) begin fail_count++; $display("FAIL and got %h/%b want 00/0001", BusOut, Flags); end
    do_op(8'hA0, 8'h05, 3'd3, edges);
    cmp_count++; if ({BusOut, Flags} !== {8'hA5, 4'b1000}) begin fail_count++; $display("FAIL or got %h/%b want A5/1000", BusOut, Flags); end
    do_op(8'hFF, 8'h0F, 3'd4, edges);
    cmp_count++; if ({BusOut, Flags} !== {8'hF0, 4'b1000}) begin fail_count++; $display("FAIL xor got %h/%b want F0/1000", BusOut, Flags); end
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul;
    int edges;
    @(negedge Clock);
    Accumulator = 8'hFF; BRegister = 8'hFF; Operation = 3'd7; Start = 1'b1;
    @(negedge Clock);
    // Keep Start high and scramble operands while busy; neither may affect the op
    Accumulator = 8'h00; BRegister = 8'h00; Operation = 3'd0;
    cmp_count++; if (Busy !== 1'b1) begin fail_count++; $display("FAIL mul_busy got %b want 1", Busy); end
    cmp_count++; if (BusOut !== 8'hF0) begin fail_count++; $display("FAIL mul_prev_result got %h want F0", BusOut); end
    edges = 0;
    while (Done !== 1'b1 && edges < 40) begin
      @(negedge Clock);
      edges++;
    end
    Start = 1'b0;
    cmp_count++; if (edges !== 8) begin fail_count++; $display("FAIL mul_latency got %0d want 8", edges); end
    cmp_count++; if ({BusOut, ProductHigh, Flags} !== {8'h01, 8'hFE, 4'b0110}) begin fail_count++; $display("FAIL mul_ff got %h/%h/%b want 01/FE/0110", BusOut, ProductHigh, Flags); end
    @(negedge Clock);
    cmp_count++; if ({Busy, Done} !== 2'b00) begin fail_count++; $display("FAIL mul_idle got %b want 00", {Busy, Done}); end
  endtask
`else
  task automatic test_mul;
    int edges;
    do_op(8'h55, 8'h33, 3'd7, edges);
    cmp_count++; if (edges !== 0) begin fail_count++; $display("FAIL pass_latency got %0d want 0", edges); end
    cmp_count++; if ({BusOut, ProductHigh, Flags} !== {8'h55, 8'h00, 4'b0000}) begin fail_count++; $display("FAIL pass_55 got %h/%h/%b want 55/00/0000", BusOut, ProductHigh, Flags); end
    do_op(8'h80, 8'hFF, 3'd7, edges);
    cmp_count++; if ({BusOut, ProductHigh, Flags} !== {8'h80, 8'h00, 4'b1000}) begin fail_count++; $display("FAIL pass_80 got %h/%h/%b want 80/00/1000", BusOut, ProductHigh, Flags); end
  endtask
`endif

  task automatic test_ph_hold;
    int edges;
    logic [7:0] ph_want;
`ifdef ALU_MUL_EN
    ph_want = 8'hFE;
`else
    ph_want = 8'h00;
`endif
    do_op(8'h03, 8'h04, 3'd0, edges);
    cmp_count++; if ({BusOut, ProductHigh} !== {8'h07, ph_want}) begin fail_count++; $display("FAIL ph_hold got %h/%h want 07/%h", BusOut, ProductHigh, ph_want); end
  endtask

  task automatic test_back_to_back;
    int dones, busys;
    logic [5:0] done_pat;
    dones = 0; busys = 0; done_pat = '0;
    @(negedge Clock);
    Accumulator = 8'h01; BRegister = 8'h01; Operation = 3'd0; Start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      done_pat = {done_pat[4:0], Done};
      if (Done === 1'b1) dones++;
      if (Busy === 1'b1) busys++;
    end
    Start = 1'b0;
    cmp_count++; if (done_pat !== 6'b101010) begin fail_count++; $display("FAIL b2b_pattern got %b want 101010", done_pat); end
    cmp_count++; if ({dones, busys} !== {32'd3, 32'd3}) begin fail_count++; $display("FAIL b2b_counts got %0d/%0d want 3/3", dones, busys); end
    @(negedge Clock);
  endtask

  task automatic test_reset_abort;
    int edges, dones;
`ifdef ALU_MUL_EN
    @(negedge Clock);
    Accumulator = 8'h0F; BRegister = 8'h11; Operation = 3'd7; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (3) @(negedge Clock);
    cmp_count++; if ({Busy, Done} !== 2'b10) begin fail_count++; $display("FAIL abort_inflight got %b want 10", {Busy, Done}); end
`else
    do_op(8'h55, 8'h00, 3'd7, edges);
`endif
    Reset = 1'b1; #1;
    cmp_count++; if ({BusOut, ProductHigh, Flags, Busy, Done} !== 22'b0) begin fail_count++; $display("FAIL abort_clear got %h/%h/%b/%b/%b want all 0", BusOut, ProductHigh, Flags, Busy, Done); end
    @(negedge Clock);
    Reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clock);
      if (Done === 1'b1 || Busy === 1'b1) dones++;
    end
    cmp_count++; if (dones !== 0) begin fail_count++; $display("FAIL abort_no_done got %0d active cycles want 0", dones); end
`ifdef ALU_MUL_EN
    do_op(8'h0F, 8'h11, 3'd7, edges);
    cmp_count++; if (edges !== 8) begin fail_count++; $display("FAIL remul_latency got %0d want 8", edges); end
    cmp_count++; if ({BusOut, ProductHigh, Flags} !== {8'hFF, 8'h00, 4'b1000}) begin fail_count++; $display("FAIL remul got %h/%h/%b want FF/00/1000", BusOut, ProductHigh, Flags); end
`else
    do_op(8'h0F, 8'h11, 3'd7, edges);
    cmp_count++; if ({BusOut, ProductHigh, Flags} !== {8'h0F, 8'h00, 4'b0000}) begin fail_count++; $display("FAIL repass got %h/%h/%b want 0F/00/0000", BusOut, ProductHigh, Flags); end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic_shift();
    test_mul();
    test_ph_hold();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
